rename_ctrl: RTL and testbench

RENAME_CTRL -- requirements
Module: rename_ctrl

---
 rtl/rename_ctrl_pkg.sv | 48 ++++
 rtl/rename_ctrl_tag_alloc.sv | 80 ++++++++
 rtl/rename_ctrl.sv | 133 +++++++++++++
 tb/tb_rename_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_ctrl_pkg.sv
// Shared core definitions for the rename stage: decoded-packet geometry,
// register-pool and checkpoint sizing, and small combinational helpers.
package rename_ctrl_pkg;

   // Core geometry that the decoded packet layout is built from
   localparam int SIZE_SPECIAL_REG    = 2;
   localparam int LDST_TYPES_LOG      = 2;
   localparam int INST_TYPES_LOG      = 2;
   localparam int SIZE_IMMEDIATE      = 16;
   localparam int SIZE_RMT_LOG        = 5;
   localparam int SIZE_OPCODE_I       = 8;
   localparam int SIZE_PC             = 32;
   localparam int SIZE_CTI_LOG        = 2;

   // Register pool and branch checkpoint sizing
   localparam int SIZE_RMT            = 32;
   localparam int SIZE_PHYSICAL_TABLE = 96;
   localparam int SIZE_PHYSICAL_LOG   = 7;
   localparam int CORE_CHECKPOINTS    = 8;
   localparam int CHECKPOINTS_LOG     = 3;
   localparam int BRANCH_COUNT        = 3;
   localparam int DISPATCH_WIDTH      = 4;

   // Full decoded packet width
   localparam int CORE_PKT_W = 2*SIZE_SPECIAL_REG + 3 + LDST_TYPES_LOG + INST_TYPES_LOG
                             + SIZE_IMMEDIATE + 1 + 3*SIZE_RMT_LOG + 3 + SIZE_OPCODE_I
                             + 2*SIZE_PC + SIZE_CTI_LOG + 1;

   // Position of the "is a control-transfer" flag inside a packet
   localparam int CORE_BRANCH_BIT = 3 + LDST_TYPES_LOG + INST_TYPES_LOG + SIZE_IMMEDIATE + 1
                                  + 3*SIZE_RMT_LOG + 3 + SIZE_OPCODE_I + 2*SIZE_PC
                                  + SIZE_CTI_LOG;

   // Physical registers that are free once the architectural map is populated
   localparam int CORE_FREE_REGS = SIZE_PHYSICAL_TABLE - SIZE_RMT;

   // Free-count width holds 0..SIZE_PHYSICAL_TABLE inclusive
   localparam int FREE_W = SIZE_PHYSICAL_LOG + 1;

   typedef logic [CHECKPOINTS_LOG-1:0] tag_t;
   typedef logic [FREE_W-1:0]          free_cnt_t;

   // Number of set bits in a four-slot mask (0..4)
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/rename_ctrl_tag_alloc.sv
// Branch checkpoint allocator: tracks unresolved branches in flight, owns the
// rotating tag pointer and hands out one tag per branch slot in slot order.
module rename_tag_alloc
   import rename_ctrl_pkg::*;
#(
   parameter int CHECKPOINTS = CORE_CHECKPOINTS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                flush_i,
   input  logic                                fire_i,
   input  logic [3:0]                          branch_slots_i,
   input  logic [BRANCH_COUNT-1:0]             branch_count_i,
   input  logic [2:0]                          branch_resolved_i,
   output logic                                ckpt_full_o,
   output logic [3:0][CHECKPOINTS_LOG-1:0]     slot_tag_o
);

   // Outstanding holds 0..CHECKPOINTS inclusive; sums get headroom for +7
   localparam int OUT_W = $clog2(CHECKPOINTS + 1);
   localparam int SUM_W = OUT_W + 3;

   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   tag_t             tag_ptr_q, tag_ptr_d;
   logic [2:0]       rank;
   logic [2:0]       nbranch;
   logic [SUM_W-1:0] demand;
   logic [SUM_W-1:0] credit;

   // Would accepting this window's branches overrun the checkpoint pool?
   always_comb begin
      demand      = SUM_W'(outstanding_q) + SUM_W'(branch_count_i);
      ckpt_full_o = (demand > SUM_W'(CHECKPOINTS));
   end

   // Assign consecutive tags to branch slots, lowest slot first, wrapping
   always_comb begin
      rank = 3'd0;
      for (int i = 0; i < 4; i++) begin
         slot_tag_o[i] = '0;
         if (branch_slots_i[i]) begin
            slot_tag_o[i] = CHECKPOINTS_LOG'((int'(tag_ptr_q) + int'(rank)) % CHECKPOINTS);
            rank          = rank + 3'd1;
         end
      end
      nbranch = rank;
   end

   // Next checkpoint occupancy and pointer; a flush discards all speculation
   always_comb begin
      credit        = SUM_W'(outstanding_q) + (fire_i ? SUM_W'(branch_count_i) : '0);
      outstanding_d = outstanding_q;
      tag_ptr_d     = tag_ptr_q;
      if (flush_i) begin
         outstanding_d = '0;
         tag_ptr_d     = '0;
      end else begin
         outstanding_d = OUT_W'(credit - SUM_W'(branch_resolved_i));
         if (fire_i) begin
            tag_ptr_d = tag_t'((int'(tag_ptr_q) + int'(nbranch)) % CHECKPOINTS);
         end
      end
   end

   // Checkpoint state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding_q <= '0;
         tag_ptr_q     <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         tag_ptr_q     <= tag_ptr_d;
      end
   end

   // Commit can never resolve more branches than are in flight
   a_no_underflow : assert property (@(posedge clk) disable iff (reset)
      flush_i || (credit >= SUM_W'(branch_resolved_i)));

endmodule

// File: rtl/rename_ctrl.sv
// Rename-stage controller: decides whether the four-wide dispatch window can be
// renamed this cycle (enough free physical registers and branch checkpoints),
// latches accepted windows with their branch tags, and keeps the free pool count.
module rename_ctrl
   import rename_ctrl_pkg::*;
#(
   parameter int PKT_W       = CORE_PKT_W,
   parameter int FREE_REGS   = CORE_FREE_REGS,
   parameter int CHECKPOINTS = CORE_CHECKPOINTS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic                         instBufferReady_i,
   input  logic [PKT_W-1:0]             decodedPacket0_i,
   input  logic [PKT_W-1:0]             decodedPacket1_i,
   input  logic [PKT_W-1:0]             decodedPacket2_i,
   input  logic [PKT_W-1:0]             decodedPacket3_i,
   input  logic [3:0]                   destVector_i,
   input  logic [BRANCH_COUNT-1:0]      branchCount_i,
   input  logic [2:0]                   freedRegs_i,
   input  logic [2:0]                   branchResolved_i,
   input  logic                         dispatchStall_i,
   output logic                         stall_o,
   output logic                         renameReady_o,
   output logic [PKT_W-1:0]             decodedPacket0_o,
   output logic [PKT_W-1:0]             decodedPacket1_o,
   output logic [PKT_W-1:0]             decodedPacket2_o,
   output logic [PKT_W-1:0]             decodedPacket3_o,
   output logic [CHECKPOINTS_LOG-1:0]   branchTag0_o,
   output logic [CHECKPOINTS_LOG-1:0]   branchTag1_o,
   output logic [CHECKPOINTS_LOG-1:0]   branchTag2_o,
   output logic [CHECKPOINTS_LOG-1:0]   branchTag3_o,
   output logic [SIZE_PHYSICAL_LOG:0]   freeCount_o
);

   logic [3:0][PKT_W-1:0]           pkt_in;
   logic [3:0][PKT_W-1:0]           pkt_q, pkt_d;
   logic [3:0][CHECKPOINTS_LOG-1:0] slot_tag;
   logic [3:0][CHECKPOINTS_LOG-1:0] tag_q, tag_d;
   logic [3:0]                      branch_slots;
   logic [2:0]                      need;
   logic                            ckpt_full;
   logic                            stall;
   logic                            fire;
   logic                            ready_q, ready_d;
   free_cnt_t                       free_count_q, free_count_d;

   assign pkt_in = {decodedPacket3_i, decodedPacket2_i, decodedPacket1_i, decodedPacket0_i};

   // Branch flag of each slot selects which slots consume a checkpoint tag
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         branch_slots[i] = pkt_in[i][CORE_BRANCH_BIT];
      end
   end

   rename_tag_alloc #(
      .CHECKPOINTS       (CHECKPOINTS)
   ) u_tag_alloc (
      .clk               (clk),
      .reset             (reset),
      .flush_i           (flush_i),
      .fire_i            (fire),
      .branch_slots_i    (branch_slots),
      .branch_count_i    (branchCount_i),
      .branch_resolved_i (branchResolved_i),
      .ckpt_full_o       (ckpt_full),
      .slot_tag_o        (slot_tag)
   );

   // Accept decision: resources are checked against current state only, so
   // registers released this cycle become usable from the next cycle on
   always_comb begin
      need  = popcount4(destVector_i);
      stall = dispatchStall_i | (free_count_q < FREE_W'(need)) | ckpt_full;
      fire  = instBufferReady_i & ~stall & ~flush_i;
   end

   // Free pool: allocation and commit release apply together; flush keeps it
   always_comb begin
      free_count_d = free_count_q - (fire ? FREE_W'(need) : '0) + FREE_W'(freedRegs_i);
   end

   // Output latch: flush drops the window, back-pressure holds it, otherwise
   // an idle cycle empties it
   always_comb begin
      ready_d = ready_q;
      pkt_d   = pkt_q;
      tag_d   = tag_q;
      if (flush_i) begin
         ready_d = 1'b0;
      end else if (fire) begin
         ready_d = 1'b1;
         pkt_d   = pkt_in;
         tag_d   = slot_tag;
      end else if (!dispatchStall_i) begin
         ready_d = 1'b0;
      end
   end

   // State registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         free_count_q <= FREE_W'(FREE_REGS);
         ready_q      <= 1'b0;
         pkt_q        <= '0;
         tag_q        <= '0;
      end else begin
         free_count_q <= free_count_d;
         ready_q      <= ready_d;
         pkt_q        <= pkt_d;
         tag_q        <= tag_d;
      end
   end

   assign stall_o          = stall;
   assign renameReady_o    = ready_q;
   assign decodedPacket0_o = pkt_q[0];
   assign decodedPacket1_o = pkt_q[1];
   assign decodedPacket2_o = pkt_q[2];
   assign decodedPacket3_o = pkt_q[3];
   assign branchTag0_o     = tag_q[0];
   assign branchTag1_o     = tag_q[1];
   assign branchTag2_o     = tag_q[2];
   assign branchTag3_o     = tag_q[3];
   assign freeCount_o      = free_count_q;

   // Commit can only return registers that were handed out
   a_free_bound : assert property (@(posedge clk) disable iff (reset)
      free_count_q <= FREE_W'(FREE_REGS));

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the rename rules.
module tb_rename_ctrl;
   import rename_ctrl_pkg::*;

   localparam int PW = CORE_PKT_W;
   localparam int FR = CORE_FREE_REGS;
   localparam int CK = CORE_CHECKPOINTS;
   localparam int BB = CORE_BRANCH_BIT;
   localparam int FW = SIZE_PHYSICAL_LOG + 1;
   localparam int TW = CHECKPOINTS_LOG;

   logic clk = 1'b0;
   logic reset, flush_i, ibr_i, dstall_i;
   logic [PW-1:0] pkt_i [4];
   logic [3:0] dest_i;
   logic [BRANCH_COUNT-1:0] bcount_i;
   logic [2:0] freed_i, resolved_i;
   logic stall_o, ready_o;
   logic [PW-1:0] pkt_o [4];
   logic [TW-1:0] tag_o [4];
   logic [FW-1:0] free_o;

   always #5 clk = ~clk;

   rename_ctrl dut (
      .clk(clk), .reset(reset), .flush_i(flush_i), .instBufferReady_i(ibr_i),
      .decodedPacket0_i(pkt_i[0]), .decodedPacket1_i(pkt_i[1]),
      .decodedPacket2_i(pkt_i[2]), .decodedPacket3_i(pkt_i[3]),
      .destVector_i(dest_i), .branchCount_i(bcount_i), .freedRegs_i(freed_i),
      .branchResolved_i(resolved_i), .dispatchStall_i(dstall_i),
      .stall_o(stall_o), .renameReady_o(ready_o),
      .decodedPacket0_o(pkt_o[0]), .decodedPacket1_o(pkt_o[1]),
      .decodedPacket2_o(pkt_o[2]), .decodedPacket3_o(pkt_o[3]),
      .branchTag0_o(tag_o[0]), .branchTag1_o(tag_o[1]),
      .branchTag2_o(tag_o[2]), .branchTag3_o(tag_o[3]),
      .freeCount_o(free_o)
   );

   // Reference model state
   int m_free, m_out, m_ptr;
   bit m_ready;
   logic [PW-1:0] m_pkt [4];
   int m_tag [4];

   int n_vec = 0;
   int n_err = 0;

   function automatic bit model_stall();
      return dstall_i || (m_free < $countones(dest_i)) || (m_out + int'(bcount_i) > CK);
   endfunction

   function automatic logic [PW-1:0] rnd_pkt(input bit br);
      logic [127:0] w;
      logic [PW-1:0] p;
      w = {$urandom, $urandom, $urandom, $urandom};
      p = w[PW-1:0];
      p[BB] = br;
      return p;
   endfunction

   task automatic set_idle();
      flush_i = 0; ibr_i = 0; dstall_i = 0; dest_i = 4'b0000;
      bcount_i = '0; freed_i = 3'd0; resolved_i = 3'd0;
   endtask

   task automatic set_window(input logic [3:0] dest, input logic [3:0] mask);
      for (int i = 0; i < 4; i++) pkt_i[i] = rnd_pkt(mask[i]);
      dest_i = dest;
      bcount_i = BRANCH_COUNT'($countones(mask));
      ibr_i = 1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Advance the model with the current inputs, then clock the DUT
   task automatic cycle();
      int need, nb;
      bit fire;
      need = $countones(dest_i);
      fire = ibr_i && !model_stall() && !flush_i;
      if (reset) begin
         m_free = FR; m_out = 0; m_ptr = 0; m_ready = 0;
         for (int i = 0; i < 4; i++) begin m_pkt[i] = '0; m_tag[i] = 0; end
      end else begin
         m_free = m_free - (fire ? need : 0) + int'(freed_i);
         if (flush_i) begin
            m_out = 0; m_ptr = 0; m_ready = 0;
         end else begin
            m_out = m_out + (fire ? int'(bcount_i) : 0) - int'(resolved_i);
            if (fire) begin
               nb = 0;
               for (int i = 0; i < 4; i++) begin
                  m_pkt[i] = pkt_i[i];
                  if (pkt_i[i][BB]) begin m_tag[i] = (m_ptr + nb) % CK; nb++; end
                  else m_tag[i] = 0;
               end
               m_ptr = (m_ptr + nb) % CK;
               m_ready = 1;
            end else if (!dstall_i) begin
               m_ready = 0;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1; set_idle();
      for (int i = 0; i < 4; i++) pkt_i[i] = '0;
      cycle(); cycle();
      reset = 0;
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      n_vec++; if (free_o !== FW'(FR)) begin n_err++; $display("FAIL reset_free: got %0d want %0d", free_o, FR); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (pkt_o[i] !== '0) begin n_err++; $display("FAIL reset_pkt%0d: got %h want 0", i, pkt_o[i]); end
         n_vec++; if (tag_o[i] !== '0) begin n_err++; $display("FAIL reset_tag%0d: got %0d want 0", i, tag_o[i]); end
      end
   endtask

   task automatic test_basic();
      set_window(4'b1111, 4'b0000);
      settle();
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL basic_stall: got %b want 0", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", ready_o); end
      n_vec++; if (free_o !== FW'(FR-4)) begin n_err++; $display("FAIL basic_free: got %0d want %0d", free_o, FR-4); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (pkt_o[i] !== pkt_i[i]) begin n_err++; $display("FAIL basic_pkt%0d: got %h want %h", i, pkt_o[i], pkt_i[i]); end
      end
      set_window(4'b0101, 4'b0000);
      cycle();
      n_vec++; if (free_o !== FW'(FR-6)) begin n_err++; $display("FAIL basic_free2: got %0d want %0d", free_o, FR-6); end
   endtask

   task automatic test_free_stall();
      int n;
      while (m_free > 2) begin
         n = (m_free - 2 > 4) ? 4 : m_free - 2;
         set_window(4'((1 << n) - 1), 4'b0000);
         cycle();
      end
      n_vec++; if (free_o !== FW'(2)) begin n_err++; $display("FAIL fs_free_pre: got %0d want 2", free_o); end
      set_window(4'b0111, 4'b0000);
      freed_i = 3'd1;
      settle();
      n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL fs_stall: got %b want 1", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL fs_ready_hold: got %b want 0", ready_o); end
      n_vec++; if (free_o !== FW'(3)) begin n_err++; $display("FAIL fs_free_rel: got %0d want 3", free_o); end
      n_vec++; if (pkt_o[0] !== m_pkt[0]) begin n_err++; $display("FAIL fs_nolatch: got %h want %h", pkt_o[0], m_pkt[0]); end
      freed_i = 3'd0;
      settle();
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fs_stall_clear: got %b want 0", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL fs_accept: got %b want 1", ready_o); end
      n_vec++; if (free_o !== FW'(0)) begin n_err++; $display("FAIL fs_free_post: got %0d want 0", free_o); end
      n_vec++; if (pkt_o[2] !== pkt_i[2]) begin n_err++; $display("FAIL fs_pkt2: got %h want %h", pkt_o[2], pkt_i[2]); end
   endtask

   task automatic test_ckpt_stall();
      set_idle(); flush_i = 1; freed_i = 3'd4;
      cycle();
      set_idle();
      set_window(4'b0000, 4'b1111); cycle();
      set_window(4'b0000, 4'b0111); cycle();
      set_window(4'b0000, 4'b0101);
      resolved_i = 3'd1;
      settle();
      n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL ck_stall: got %b want 1", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL ck_ready_hold: got %b want 0", ready_o); end
      resolved_i = 3'd0;
      settle();
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL ck_stall_clear: got %b want 0", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL ck_accept: got %b want 1", ready_o); end
      n_vec++; if (tag_o[0] !== TW'(CK-1)) begin n_err++; $display("FAIL ck_tag0: got %0d want %0d", tag_o[0], CK-1); end
      n_vec++; if (tag_o[2] !== TW'(0)) begin n_err++; $display("FAIL ck_tag2_wrap: got %0d want 0", tag_o[2]); end
   endtask

   task automatic test_tag_wrap();
      set_idle(); flush_i = 1;
      cycle();
      set_idle();
      set_window(4'b0000, 4'b1111); cycle();
      set_window(4'b0000, 4'b0111); cycle();
      ibr_i = 0; bcount_i = '0; resolved_i = 3'd4;
      cycle();
      resolved_i = 3'd0;
      set_window(4'b0000, 4'b1010);
      cycle();
      n_vec++; if (tag_o[1] !== TW'(CK-1)) begin n_err++; $display("FAIL tw_tag1: got %0d want %0d", tag_o[1], CK-1); end
      n_vec++; if (tag_o[3] !== TW'(0)) begin n_err++; $display("FAIL tw_tag3: got %0d want 0", tag_o[3]); end
      n_vec++; if (tag_o[0] !== TW'(0)) begin n_err++; $display("FAIL tw_tag0: got %0d want 0", tag_o[0]); end
      n_vec++; if (tag_o[2] !== TW'(0)) begin n_err++; $display("FAIL tw_tag2: got %0d want 0", tag_o[2]); end
   endtask

   task automatic test_dispatch_stall();
      logic [PW-1:0] held [4];
      set_window(4'b0011, 4'b0000);
      cycle();
      for (int i = 0; i < 4; i++) held[i] = pkt_i[i];
      set_window(4'b0001, 4'b0000);
      dstall_i = 1;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL ds_stall c%0d: got %b want 1", c, stall_o); end
         cycle();
         n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL ds_ready c%0d: got %b want 1", c, ready_o); end
         n_vec++; if (free_o !== FW'(2)) begin n_err++; $display("FAIL ds_free c%0d: got %0d want 2", c, free_o); end
         for (int i = 0; i < 4; i++) begin
            n_vec++; if (pkt_o[i] !== held[i]) begin n_err++; $display("FAIL ds_pkt%0d c%0d: got %h want %h", i, c, pkt_o[i], held[i]); end
         end
      end
      set_idle();
   endtask

   task automatic test_flush();
      set_window(4'b0000, 4'b0011);
      cycle();
      set_window(4'b0011, 4'b0000);
      flush_i = 1; freed_i = 3'd2;
      settle();
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", stall_o); end
      cycle();
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", ready_o); end
      n_vec++; if (free_o !== FW'(4)) begin n_err++; $display("FAIL fl_free: got %0d want 4", free_o); end
      flush_i = 0; freed_i = 3'd0;
      set_window(4'b0000, 4'b1111);
      settle();
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fl_out_clear: got %b want 0", stall_o); end
      cycle();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (tag_o[i] !== TW'(i)) begin n_err++; $display("FAIL fl_tag%0d: got %0d want %0d", i, tag_o[i], i); end
      end
   endtask

   task automatic test_random();
      logic [3:0] mask;
      int fmax, rmax;
      for (int it = 0; it < 400; it++) begin
         flush_i  = ($urandom_range(0, 19) == 0);
         dstall_i = ($urandom_range(0, 4) == 0);
         ibr_i    = ($urandom_range(0, 4) != 0);
         mask     = 4'($urandom);
         set_window(4'($urandom), mask);
         ibr_i    = ($urandom_range(0, 4) != 0);
         fmax = (FR - m_free > 4) ? 4 : FR - m_free;
         rmax = (m_out > 4) ? 4 : m_out;
         freed_i    = 3'($urandom_range(0, fmax));
         resolved_i = 3'($urandom_range(0, rmax));
         settle();
         n_vec++; if (stall_o !== model_stall()) begin n_err++; $display("FAIL rnd_stall it%0d: got %b want %b", it, stall_o, model_stall()); end
         cycle();
         n_vec++; if (ready_o !== m_ready) begin n_err++; $display("FAIL rnd_ready it%0d: got %b want %b", it, ready_o, m_ready); end
         n_vec++; if (free_o !== FW'(m_free)) begin n_err++; $display("FAIL rnd_free it%0d: got %0d want %0d", it, free_o, m_free); end
         for (int i = 0; i < 4; i++) begin
            n_vec++; if (pkt_o[i] !== m_pkt[i]) begin n_err++; $display("FAIL rnd_pkt%0d it%0d: got %h want %h", i, it, pkt_o[i], m_pkt[i]); end
            n_vec++; if (tag_o[i] !== TW'(m_tag[i])) begin n_err++; $display("FAIL rnd_tag%0d it%0d: got %0d want %0d", i, it, tag_o[i], m_tag[i]); end
         end
      end
      set_idle();
   endtask

   task automatic test_mid_reset();
      set_window(4'b0001, 4'b0011);
      freed_i = 3'd0;
      reset = 1;
      cycle();
      reset = 0;
      set_idle();
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL mr_ready: got %b want 0", ready_o); end
      n_vec++; if (free_o !== FW'(FR)) begin n_err++; $display("FAIL mr_free: got %0d want %0d", free_o, FR); end
      n_vec++; if (tag_o[1] !== TW'(0)) begin n_err++; $display("FAIL mr_tag1: got %0d want 0", tag_o[1]); end
      n_vec++; if (pkt_o[0] !== '0) begin n_err++; $display("FAIL mr_pkt0: got %h want 0", pkt_o[0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_free_stall();
      test_ckpt_stall();
      test_tag_wrap();
      test_dispatch_stall();
      test_flush();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
